tlm_get_arbiter: RTL and testbench



---
 rtl/tlm_get_arbiter.sv | 107 ++++++++++
 tb/tb_tlm_get_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlm_get_arbiter.sv
// Round-robin arbiter that lets NUM_REQ get/peek requesters share one FIFO head.
// Optional macro TLM_GET_ARBITER_TIMEOUT_EN adds a per-requester wait timeout for blocking requests.
module tlm_get_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_get,
  input  logic [NUM_REQ-1:0] req_try,
  input  logic               src_valid,
  input  logic [DATA_W-1:0]  src_data,
  output logic               src_pop,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_ok,
  output logic [DATA_W-1:0]  rsp_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_ok_q, rsp_ok_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] timeout_hit;
  logic [NUM_REQ-1:0] eligible;
  logic               grant;
  logic [PTR_W-1:0]   grant_idx;

`ifdef TLM_GET_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wait
      logic [CNT_W-1:0] wait_q;

      // Counts only cycles where a blocking request is genuinely waiting.
      always_ff @(posedge clk) begin
        if (rst || !req_valid[gi] || req_try[gi] || rsp_valid_q[gi] ||
            (grant && grant_idx == PTR_W'(gi))) begin
          wait_q <= '0;
        end else if (wait_q != CNT_W'(TIMEOUT)) begin
          wait_q <= wait_q + 1'b1;
        end
      end

      assign timeout_hit[gi] = (wait_q == CNT_W'(TIMEOUT));
    end
  endgenerate
`else
  assign timeout_hit = '0;
`endif

  // A requester still holding req_valid during its own response cycle is masked.
  assign eligible = req_valid & ~rsp_valid_q &
                    (req_try | {NUM_REQ{src_valid}} | timeout_hit);

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant && eligible[PTR_W'(idx)]) begin
        grant     = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    rsp_ok_d    = 1'b0;
    rsp_data_d  = '0;
    if (grant) begin
      ptr_d       = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rsp_valid_d = NUM_REQ'(1) << grant_idx;
      // A timeout grant only occurs with an empty source, so ok tracks src_valid.
      rsp_ok_d    = src_valid;
      rsp_data_d  = src_valid ? src_data : '0;
    end
  end

  assign src_pop = !rst && grant && req_get[grant_idx] && src_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_ok_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ok    = rsp_ok_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tlm_get_arbiter.sv
// Self-checking bench for tlm_get_arbiter: directed vector table, corner-case
// sequences, and randomized traffic checked against a behavioural model.
module tb_tlm_get_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;
`ifdef TLM_GET_ARBITER_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_get, req_try;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_pop;
  logic [N-1:0]  rsp_valid;
  logic          rsp_ok;
  logic [DW-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlm_get_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_get(req_get), .req_try(req_try),
    .src_valid(src_valid), .src_data(src_data), .src_pop(src_pop),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_data(rsp_data)
  );

  typedef struct {
    logic          r;
    logic [N-1:0]  v, g, t;
    logic          sv;
    logic [DW-1:0] sd;
    logic          pop;
    logic [N-1:0]  rv;
    logic          ok;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [N-1:0] g,
                              input logic [N-1:0] t, input logic sv, input logic [DW-1:0] sd,
                              input logic pop, input logic [N-1:0] rv, input logic ok,
                              input logic [DW-1:0] d);
    vec_t x;
    x.r = r; x.v = v; x.g = g; x.t = t; x.sv = sv; x.sd = sd;
    x.pop = pop; x.rv = rv; x.ok = ok; x.d = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] g,
                       input logic [N-1:0] t, input logic sv, input logic [DW-1:0] sd);
    rst = r; req_valid = v; req_get = g; req_try = t; src_valid = sv; src_data = sd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: pointer as an integer, response as a granted index.
  int            m_ptr;
  int            m_rv;
  logic          m_ok;
  logic [DW-1:0] m_data;
  int            m_wait [N];

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i] && m_rv != i &&
          (req_try[i] || src_valid || (TE && m_wait[i] >= TMO)))
        return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rv = -1; m_ok = 1'b0; m_data = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic model_step(input int g);
    int old_rv;
    if (rst) begin
      model_reset();
      return;
    end
    old_rv = m_rv;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || req_try[i] || i == g || i == old_rv) m_wait[i] = 0;
      else if (m_wait[i] < TMO) m_wait[i] = m_wait[i] + 1;
    end
    m_rv   = g;
    m_ok   = (g >= 0) && src_valid;
    m_data = ((g >= 0) && src_valid) ? src_data : '0;
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  initial begin
    logic [N-1:0]  exp_rv;
    logic          p;
    int            item;
    int            seen;
    logic          stray;
    int            g;

    tbl[0]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0001, 1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 32'hA5A5_0001, 1'b1, 4'b0000, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0100, 1'b1, 32'hA5A5_0001);
    tbl[7]  = mk(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b1000, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 4'b1010, 4'b1000, 4'b0000, 1'b1, 32'h1234,      1'b0, 4'b0000, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 4'b1010, 4'b1000, 4'b0000, 1'b1, 32'h1234,      1'b1, 4'b0010, 1'b1, 32'h1234);
    tbl[11] = mk(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 32'h1234,      1'b0, 4'b1000, 1'b1, 32'h1234);
    tbl[12] = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0);

    drive(1'b1, '0, '0, '0, 1'b0, '0);
    next_cycle();
    next_cycle();

    // Directed table: try on empty, blocking fill, peek-before-get.
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].r, tbl[r].v, tbl[r].g, tbl[r].t, tbl[r].sv, tbl[r].sd);
      @(negedge clk);
      check($sformatf("tbl%0d.pop", r), 64'(src_pop),   64'(tbl[r].pop));
      check($sformatf("tbl%0d.rv", r),  64'(rsp_valid), 64'(tbl[r].rv));
      check($sformatf("tbl%0d.ok", r),  64'(rsp_ok),    64'(tbl[r].ok));
      check($sformatf("tbl%0d.d", r),   64'(rsp_data),  64'(tbl[r].d));
      $display("vec %0d: v=%b pop=%b rv=%b ok=%b d=%h", r, req_valid, src_pop, rsp_valid, rsp_ok, rsp_data);
      next_cycle();
    end

    // Round robin: all four blocking gets held, one item per cycle.
    drive(1'b1, '0, '0, '0, 1'b0, '0);
    next_cycle();
    item = 0;
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, DW'(item));
      @(negedge clk);
      p = src_pop;
      check($sformatf("rr%0d.pop", k), 64'(src_pop), 64'(1));
      if (k > 0) begin
        exp_rv = '0;
        exp_rv[(k - 1) % N] = 1'b1;
        check($sformatf("rr%0d.rv", k), 64'(rsp_valid), 64'(exp_rv));
        check($sformatf("rr%0d.d", k),  64'(rsp_data),  64'(k - 1));
        check($sformatf("rr%0d.ok", k), 64'(rsp_ok),    64'(1));
      end
      $display("rr %0d: rv=%b d=%h", k, rsp_valid, rsp_data);
      next_cycle();
      if (p) item++;
    end

    // Reset mid-transaction discards the response and resets the pointer.
    drive(1'b1, '0, '0, '0, 1'b0, '0);
    next_cycle();
    drive(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 32'h77);
    @(negedge clk);
    check("rst.pop_before", 64'(src_pop), 64'(1));
    next_cycle();
    drive(1'b1, 4'b0110, 4'b0110, 4'b0110, 1'b1, 32'h78);
    @(negedge clk);
    check("rst.pop_in_reset", 64'(src_pop), 64'(0));
    next_cycle();
    drive(1'b0, 4'b1001, 4'b0000, 4'b1001, 1'b0, 32'h0);
    @(negedge clk);
    check("rst.rv_discarded", 64'(rsp_valid), 64'(0));
    next_cycle();
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    check("rst.ptr_zero", 64'(rsp_valid), 64'(4'b0001));
    $display("reset seq: rv=%b", rsp_valid);
    next_cycle();

    // Blocking peek on an empty source.
    drive(1'b1, '0, '0, '0, 1'b0, '0);
    next_cycle();
    seen  = -1;
    stray = 1'b0;
`ifdef TLM_GET_ARBITER_TIMEOUT_EN
    drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (src_pop) stray = 1'b1;
      if (rsp_valid != '0) begin
        seen = c;
        check("tmo.rv", 64'(rsp_valid), 64'(4'b0001));
        check("tmo.ok", 64'(rsp_ok), 64'(0));
        check("tmo.d",  64'(rsp_data), 64'(0));
        next_cycle();
        break;
      end
      next_cycle();
    end
    check("tmo.cycle", 64'(seen), 64'(TMO + 1));
    check("tmo.nopop", 64'(stray), 64'(0));
    $display("timeout seq: response in cycle %0d", seen);
`else
    drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, '0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (src_pop || rsp_valid != '0) stray = 1'b1;
      next_cycle();
    end
    check("wait.pending", 64'(stray), 64'(0));
    drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 32'h55);
    @(negedge clk);
    check("wait.peek_nopop", 64'(src_pop), 64'(0));
    next_cycle();
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, '0);
    @(negedge clk);
    check("wait.rv", 64'(rsp_valid), 64'(4'b0001));
    check("wait.ok", 64'(rsp_ok), 64'(1));
    check("wait.d",  64'(rsp_data), 64'(32'h55));
    $display("wait seq: rv=%b d=%h", rsp_valid, rsp_data);
    next_cycle();
`endif

    // Randomized traffic against the reference model.
    drive(1'b1, '0, '0, '0, 1'b0, '0);
    next_cycle();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (rsp_valid[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0))
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_get[i]   = 1'($urandom_range(0, 1));
          req_try[i]   = ($urandom_range(0, 2) == 0);
        end
      end
      src_valid = ($urandom_range(0, 9) < 6);
      src_data  = $urandom;
      @(negedge clk);
      g = model_grant();
      exp_rv = '0;
      if (m_rv >= 0) exp_rv[m_rv] = 1'b1;
      check("rnd.pop", 64'(src_pop),
            64'(!rst && g >= 0 && req_get[g >= 0 ? g : 0] && src_valid));
      check("rnd.rv", 64'(rsp_valid), 64'(exp_rv));
      check("rnd.ok", 64'(rsp_ok),    64'(m_ok));
      check("rnd.d",  64'(rsp_data),  64'(m_data));
      @(posedge clk);
      model_step(g);
      #1;
    end
    $display("random: 2000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
